seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Downstream stage of the cpu: consumes its four 8-bit display outputs and time-multiplexes them onto one shared 4-digit 7-segment panel.
- Drives one common segment bus plus four active-low digit enables.
- Each digit slot starts with a short blanking window to suppress ghosting.
- Emits a one-cycle frame pulse each time all four digits have been scanned.

Parameters:
- PRESCALE, 50000, clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; must be < PRESCALE; 0 disables blanking.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  display enable; 0 forces the panel dark.
- display0  input  8  pattern for digit 0 (rightmost); bit0=a … bit6=g, bit7=dp, 1=lit.
- display1  input  8  pattern for digit 1.
- display2  input  8  pattern for digit 2.
- display3  input  8  pattern for digit 3 (leftmost).
- seg  output  8  segment bus, same bit order as the inputs, active-high.
- an  output  4  digit enables, active-low; an[k] selects digit k.
- frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, idx=0, an=4'b1111, seg=8'h00, frame_done=0.
  - Takes effect immediately, including mid-slot.
  - Scanning restarts at slot 0, blank phase, on release.
- Counters:
  - cnt runs 0..PRESCALE-1 and wraps.
  - On wrap, idx increments 3→0 circularly.
  - Both counters keep running regardless of en.
- Slot phases, for slot idx=k:
  - Blank phase, cnt in 0..BLANK_CYCLES-1: an=4'b1111, seg=8'h00.
  - Visible phase, cnt in BLANK_CYCLES..PRESCALE-1: an has only bit k low; seg holds the latched pattern.
- Capture:
  - The pattern register loads displayk on the clock edge where the state enters the visible phase: cnt becomes BLANK_CYCLES with idx=k.
  - With BLANK_CYCLES=0, that edge is the slot boundary, and the next idx value selects the input.
  - Input changes during the visible phase have no effect until that digit's next capture.
- Outputs: seg, an and frame_done are all registered; no combinational path from inputs to outputs.
- Enable:
  - en=0 sampled at an edge → an=4'b1111, seg=8'h00 after that edge.
  - en=1 at an edge inside a visible phase → after that edge, an and seg show the current slot with a freshly captured pattern for digit idx.
  - Visible-phase semantics otherwise unchanged.
- frame_done:
  - 1 for exactly one cycle, following the edge where idx wraps 3→0 (cnt becomes 0).
  - Unaffected by en.
- Simultaneous events: reset overrides everything; en=0 overrides capture and display.

Optional Feature:
- Macro: SEG_DISPLAY_HEX_DECODE_EN.
- Defined: each input is treated as a hex value.
  - Bits 3:0 are decoded to segments: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Bit 7 drives dp directly; bits 6:4 are ignored.
  - Decoding happens before the capture register; latency is unchanged.
- Undefined: inputs pass through as raw segment patterns, with no decode logic present.

Test Plan (PRESCALE=8, BLANK_CYCLES=2; "edge n" = nth rising edge after reset release):
1. Hold reset=0 with clk running and inputs toggling → an=4'b1111, seg=8'h00, frame_done=0 throughout.
2. Raw mode, en=1, display0..3 = 3F/06/5B/4F:
   - Blank after edges 0–1.
   - an=1110, seg=3F after edges 2–7.
   - Blank after edges 8–9; an=1101, seg=06 after edges 10–15.
   - an=1011, seg=5B after edges 18–23; an=0111, seg=4F after edges 26–31.
   - frame_done=1 only after edge 32; the pattern repeats.
3. Change display1 from 06 to 66 after edge 12 → seg stays 06 through edge 15; the next frame shows 66 after edges 42–47.
4. en=0 sampled at edge 20:
   - an=1111, seg=00 after edge 20.
   - frame_done still pulses after edges 32 and 64.
   - en=1 at edge 36 → an=1110, seg=3F after edge 36.
5. Assert reset between edges 12 and 13 → outputs dark immediately; after release, digit 0 visible after edges 2–7 again.
6. With SEG_DISPLAY_HEX_DECODE_EN defined, display0=8'h85, display1=8'h0A → seg=ED in slot 0 and 77 in slot 1. Without the macro, the same stimulus gives seg=85 and 0A.

Source files
------------

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with per-slot blanking and a frame pulse.
// Optional build macro SEG_DISPLAY_HEX_DECODE_EN decodes each input nibble to segments.
module seg_display_scan #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] display0,
  input  logic [7:0] display1,
  input  logic [7:0] display2,
  input  logic [7:0] display3,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST_C  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    pat_q, pat_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;
  logic          wrap;
  logic          vis_d;
  logic          enter_d;
  logic          capture;
  logic [7:0]    sel_raw;

`ifdef SEG_DISPLAY_HEX_DECODE_EN
  logic unused_hi_bits;
  assign unused_hi_bits = ^sel_raw[6:4];

  function automatic logic [7:0] slot_pattern(input logic dp, input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return {dp, s};
  endfunction

  logic [7:0] sel_pat;
  assign sel_pat = slot_pattern(sel_raw[7], sel_raw[3:0]);
`else
  logic [7:0] sel_pat;
  assign sel_pat = sel_raw;
`endif

  // Input chosen by the slot the scanner is about to be in after this edge.
  always_comb begin
    case (idx_d)
      2'd0:    sel_raw = display0;
      2'd1:    sel_raw = display1;
      2'd2:    sel_raw = display2;
      default: sel_raw = display3;
    endcase
  end

  // Next-state: counters free-run; outputs derive from the post-edge slot/phase.
  always_comb begin
    wrap    = (cnt_q == LAST_C);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    vis_d   = (BLANK_CYCLES == 0) ? 1'b1 : (cnt_d >= BLANK_C);
    enter_d = (cnt_d == BLANK_C);
    // A dark panel re-lit mid-slot must show a fresh pattern, not a stale one.
    capture = en && vis_d && (enter_d || (an_q == 4'b1111));
    pat_d   = capture ? sel_pat : pat_q;
    an_d    = (en && vis_d) ? ~(4'b0001 << idx_d) : 4'b1111;
    seg_d   = (en && vis_d) ? pat_d : 8'h00;
    fd_d    = wrap && (idx_q == 2'd3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= 8'h00;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      fd_q  <= fd_d;
    end
  end

  always_ff @(posedge clk) begin
    pat_q <= pat_d;
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan at PRESCALE=8, BLANK_CYCLES=2.
module tb_seg_display_scan;
  localparam int PS = 8;
  localparam int BL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] dsp [4];
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int n = 0;
  bit shown = 1'b0;
  logic [7:0] mpat = 8'h00;
  logic [12:0] sbq [$];

  seg_display_scan #(.PRESCALE(PS), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .en(en),
    .display0(dsp[0]), .display1(dsp[1]), .display2(dsp[2]), .display3(dsp[3]),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expect_seg(input logic [7:0] v);
`ifdef SEG_DISPLAY_HEX_DECODE_EN
    logic [6:0] s;
    case (v[3:0])
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return {v[7], s};
`else
    return v;
`endif
  endfunction

  // One rising edge: predict from edge count, push, then pop/compare on the falling edge.
  task automatic step();
    logic [12:0] e;
    logic [12:0] got;
    logic [3:0]  a_e;
    logic [7:0]  s_e;
    logic        f_e;
    int cnt, idx;
    bit vis;
    @(posedge clk);
    n++;
    cnt = n % PS;
    idx = (n / PS) % 4;
    vis = (cnt >= BL);
    if (en && vis) begin
      if (cnt == BL || !shown) mpat = expect_seg(dsp[idx]);
      a_e = 4'b1111;
      a_e[idx] = 1'b0;
      s_e = mpat;
    end else begin
      a_e = 4'b1111;
      s_e = 8'h00;
    end
    shown = en && vis;
    f_e = (n % (4 * PS) == 0);
    sbq.push_back({a_e, s_e, f_e});
    @(negedge clk);
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty n=%0d", n);
    end else begin
      e = sbq.pop_front();
      got = {an, seg, frame_done};
      if (got !== e) begin
        errors++;
        $display("FAIL scan n=%0d got an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                 n, got[12:9], got[8:1], got[0], e[12:9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 8'h00 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate got an=%b seg=%h fd=%b expected an=1111 seg=00 fd=0",
               an, seg, frame_done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    shown = 1'b0;
    sbq.delete();
  endtask

  task automatic set_default_inputs();
    dsp[0] = 8'h3F; dsp[1] = 8'h06; dsp[2] = 8'h5B; dsp[3] = 8'h4F;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) dsp[k] = 8'($urandom);
      checks++;
      if (an !== 4'b1111 || seg !== 8'h00 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got an=%b seg=%h fd=%b expected an=1111 seg=00 fd=0",
                 i, an, seg, frame_done);
      end
    end
  endtask

  task automatic test_raw_scan();
    set_default_inputs();
    en = 1'b1;
    do_reset();
    for (int i = 0; i < 66; i++) begin
      step();
      if (n == 2 || n == 10 || n == 18 || n == 26) begin
        logic [3:0] a_x;
        logic [7:0] s_x;
        a_x = (n == 2) ? 4'b1110 : (n == 10) ? 4'b1101 : (n == 18) ? 4'b1011 : 4'b0111;
        s_x = expect_seg((n == 2) ? 8'h3F : (n == 10) ? 8'h06 : (n == 18) ? 8'h5B : 8'h4F);
        checks++;
        if (an !== a_x || seg !== s_x) begin
          errors++;
          $display("FAIL raw_slot n=%0d got an=%b seg=%h expected an=%b seg=%h", n, an, seg, a_x, s_x);
        end
      end
      if (n == 32 || n == 31 || n == 33) begin
        checks++;
        if (frame_done !== (n == 32)) begin
          errors++;
          $display("FAIL frame_pulse n=%0d got fd=%b expected fd=%b", n, frame_done, (n == 32));
        end
      end
    end
  endtask

  task automatic test_hold_input();
    set_default_inputs();
    en = 1'b1;
    do_reset();
    repeat (12) step();
    dsp[1] = 8'h66;
    for (int i = 0; i < 36; i++) begin
      step();
      if (n == 15 || n == 42) begin
        checks++;
        if (seg !== expect_seg((n == 15) ? 8'h06 : 8'h66)) begin
          errors++;
          $display("FAIL hold_input n=%0d got seg=%h expected seg=%h", n, seg,
                   expect_seg((n == 15) ? 8'h06 : 8'h66));
        end
      end
    end
  endtask

  task automatic test_enable();
    set_default_inputs();
    en = 1'b1;
    do_reset();
    repeat (19) step();
    en = 1'b0;
    repeat (16) step();
    en = 1'b1;
    for (int i = 0; i < 35; i++) begin
      step();
      if (n == 36) begin
        checks++;
        if (an !== 4'b1110 || seg !== expect_seg(8'h3F)) begin
          errors++;
          $display("FAIL enable_relight got an=%b seg=%h expected an=1110 seg=%h", an, seg, expect_seg(8'h3F));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_default_inputs();
    en = 1'b1;
    do_reset();
    repeat (12) step();
    do_reset();
    repeat (12) step();
  endtask

  task automatic test_hex();
    set_default_inputs();
    dsp[0] = 8'h85;
    dsp[1] = 8'h0A;
    en = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      if (n == 2 || n == 10) begin
        logic [7:0] s_x;
`ifdef SEG_DISPLAY_HEX_DECODE_EN
        s_x = (n == 2) ? 8'hED : 8'h77;
`else
        s_x = (n == 2) ? 8'h85 : 8'h0A;
`endif
        checks++;
        if (seg !== s_x) begin
          errors++;
          $display("FAIL hex_slot n=%0d got seg=%h expected seg=%h", n, seg, s_x);
        end
      end
    end
  endtask

  initial begin
    set_default_inputs();
    test_reset();
    test_raw_scan();
    test_hold_input();
    test_enable();
    test_reset_mid();
    test_hex();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
